// File: rtl/button_conditioner_pkg.sv
// Shared types and helpers for the push-button conditioner.
// Channel FSM states and counter sizing used by every button channel.
package button_conditioner_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DB_PRESS,
      ST_HELD,
      ST_REPEAT,
      ST_DB_REL
   } btn_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Counter must hold the largest terminal count without wrapping.
   function automatic int cnt_width(input int a, input int b, input int c);
      return (max3(a, b, c) < 1) ? 1 : $clog2(max3(a, b, c) + 1);
   endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button: 2-FF synchroniser, polarity fold, and debounce/auto-repeat FSM.
// All timing advances only on i_tick; a change of the synchronised level beats a tick.
module button_conditioner_channel
   import button_conditioner_pkg::*;
#(
   parameter bit ACTIVE_LOW     = 1'b1,
   parameter int DEBOUNCE_TICKS = 10,
   parameter int REPEAT_DELAY   = 50,
   parameter int REPEAT_PERIOD  = 10,
   parameter bit REPEAT_EN      = 1'b1
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_tick,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_release
);

   localparam int CNT_MAX = max3(DEBOUNCE_TICKS, REPEAT_DELAY, REPEAT_PERIOD);
   localparam int CNT_W   = cnt_width(DEBOUNCE_TICKS, REPEAT_DELAY, REPEAT_PERIOD);

   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TICKS);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD);

   logic             sync_meta;
   logic             sync_out;
   logic             pressed;
   btn_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;

   // Synchroniser resets to the released pin level so reset never looks like a press.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync_meta <= ACTIVE_LOW;
         sync_out  <= ACTIVE_LOW;
      end else begin
         sync_meta <= i_btn;
         sync_out  <= sync_meta;
      end
   end

   assign pressed = ACTIVE_LOW ? ~sync_out : sync_out;
   assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);

   // Comparisons use the incremented value so the strobe lands on the tick that reaches the target.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         o_level   <= 1'b0;
         o_press   <= 1'b0;
         o_release <= 1'b0;
      end else begin
         o_press   <= 1'b0;
         o_release <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pressed) begin
                  state <= ST_DB_PRESS;
                  cnt   <= '0;
               end
            end
            ST_DB_PRESS: begin
               if (!pressed) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (i_tick) begin
                  if (cnt_inc == DB_LAST) begin
                     state   <= ST_HELD;
                     cnt     <= '0;
                     o_press <= 1'b1;
                     o_level <= 1'b1;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            end
            ST_HELD: begin
               if (!pressed) begin
                  state <= ST_DB_REL;
                  cnt   <= '0;
               end else if (REPEAT_EN && i_tick) begin
                  if (cnt_inc == RD_LAST) begin
                     state   <= ST_REPEAT;
                     cnt     <= '0;
                     o_press <= 1'b1;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            end
            ST_REPEAT: begin
               if (!pressed) begin
                  state <= ST_DB_REL;
                  cnt   <= '0;
               end else if (i_tick) begin
                  if (cnt_inc == RP_LAST) begin
                     cnt     <= '0;
                     o_press <= 1'b1;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            end
            ST_DB_REL: begin
               if (pressed) begin
                  state <= ST_HELD;
                  cnt   <= '0;
               end else if (i_tick) begin
                  if (cnt_inc == DB_LAST) begin
                     state     <= ST_IDLE;
                     cnt       <= '0;
                     o_level   <= 1'b0;
                     o_release <= 1'b1;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: N_BTN independent conditioner channels.
// Produces debounced levels plus press/auto-repeat and release strobes.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int N_BTN          = 4,
   parameter bit ACTIVE_LOW     = 1'b1,
   parameter int DEBOUNCE_TICKS = 10,
   parameter int REPEAT_DELAY   = 50,
   parameter int REPEAT_PERIOD  = 10,
   parameter bit REPEAT_EN      = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_tick,
   input  logic [N_BTN-1:0] i_btn,
   output logic [N_BTN-1:0] o_level,
   output logic [N_BTN-1:0] o_press,
   output logic [N_BTN-1:0] o_release
);

   for (genvar g = 0; g < N_BTN; g++) begin : g_chan
      button_conditioner_channel #(
         .ACTIVE_LOW     (ACTIVE_LOW),
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD),
         .REPEAT_EN      (REPEAT_EN)
      ) u_chan (
         .i_clk     (i_clk),
         .i_reset_n (i_reset_n),
         .i_tick    (i_tick),
         .i_btn     (i_btn[g]),
         .o_level   (o_level[g]),
         .o_press   (o_press[g]),
         .o_release (o_release[g])
      );
   end

endmodule
